// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one signed WIDTHxWIDTH Baugh-Wooley array
// multiplier between N_REQ requesters. A grant latches the winner's operands,
// the array settles for one full cycle, and the registered product is offered
// on a valid/ready result port tagged with the requester index.
//
// Handshakes: a transfer happens on a rising edge only when valid and ready
// are both high on that port. req_ready is combinational, at most one-hot, and
// never asserts for a requester whose req_valid is low; res_valid, res_prod and
// res_id are registered and stay stable until res_ready is seen high.

// Combinational signed multiplier built as a Baugh-Wooley partial-product
// array: sign-row/sign-column terms are inverted and two constant ones
// (at weights WIDTH and 2*WIDTH-1) restore the two's complement result.
module array_multiplier #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] acc;
    logic [PW-1:0] row;

    // Sum the WIDTH shifted partial-product rows plus the correction constant.
    always_comb begin
        acc         = '0;
        row         = '0;
        acc[WIDTH]  = 1'b1;
        acc[PW-1]   = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            row = '0;
            for (int i = 0; i < WIDTH; i++) begin
                // Exactly one operand bit being a sign bit marks a negative-weight term.
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                    row[i] = ~(a_i[i] & b_i[j]);
                end else begin
                    row[i] = a_i[i] & b_i[j];
                end
            end
            acc = acc + (row << j);
        end
    end

    assign p_o = acc;
endmodule

module mult_share_arbiter #(
    parameter int WIDTH = 25,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     res_prod,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     op_a_q;
    logic [WIDTH-1:0]     op_b_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;
    logic [2*WIDTH-1:0]   res_prod_q;
    logic [ID_W-1:0]      res_id_q;
    logic                 res_valid_q;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W:0]        scan_idx;
    logic                 grant_en;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [2*WIDTH-1:0]   mult_p;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping mod N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (scan_idx >= (ID_W + 1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W + 1)'(N_REQ);
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Grants happen in IDLE, or in DONE when the pending result is being taken (back-to-back).
    always_comb begin
        grant_en  = grant_found && !rst &&
                    ((state_q == IDLE) || ((state_q == DONE) && res_ready));
        req_ready = '0;
        if (grant_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Winner's operand slice and the pointer value that follows this grant.
    always_comb begin
        sel_a    = req_a[grant_idx * WIDTH +: WIDTH];
        sel_b    = req_b[grant_idx * WIDTH +: WIDTH];
        rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    array_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mult_p)
    );

    // Controller FSM: latch on grant, capture the settled product, hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            res_prod_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        op_a_q   <= sel_a;
                        op_b_q   <= sel_b;
                        id_q     <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    res_prod_q  <= mult_p;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (grant_en) begin
                            op_a_q   <= sel_a;
                            op_b_q   <= sel_b;
                            id_q     <= grant_idx;
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= CALC;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_prod  = res_prod_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized bench for mult_share_arbiter. A reference model
// (in-flight flag, result-valid flag, pending product, rotating pointer)
// predicts every output each cycle; directed steps add fixed checks for
// known products and grant orders.
module tb_mult_share_arbiter;
    localparam int W  = 25;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   res_prod;
    logic [IW-1:0]    res_id;
    logic             busy;

    mult_share_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_id    (res_id),
        .busy      (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Per-requester operands, held until that requester is granted.
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic         reroll;

    // Reference model state
    logic           m_known;
    logic           m_busy;
    logic           m_valid;
    logic [2*W-1:0] m_prod;
    int             m_id;
    logic [2*W-1:0] pend_prod;
    int             pend_id;
    int             m_ptr;
    logic [N-1:0]   last_ready;

    function automatic logic [2*W-1:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 25'h1000000;
            1: return 25'h0FFFFFF;
            2: return 25'h1FFFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check against the
    // model, then advance the model across the rising edge.
    task automatic step(input logic [N-1:0] v, input logic rr, input logic r);
        logic         found;
        int           g;
        int           idx;
        logic [N-1:0] exp_rdy;
        req_valid = v;
        res_ready = rr;
        rst       = r;
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = opa[k];
            req_b[k*W +: W] = opb[k];
        end
        #1;
        found = 1'b0;
        g     = 0;
        if (!r && m_known && (!m_busy || (m_valid && rr))) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        exp_rdy = '0;
        if (found) exp_rdy[g] = 1'b1;
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (m_known) begin
            chk("res_valid", 64'(res_valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("res_prod", 64'(res_prod), 64'(m_prod));
            chk("res_id", 64'(res_id), 64'(m_id));
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_prod  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else begin
            if (m_valid && rr) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else if (m_busy && !m_valid) begin
                m_valid = 1'b1;
                m_prod  = pend_prod;
                m_id    = pend_id;
            end
            if (found) begin
                m_busy    = 1'b1;
                pend_prod = sprod(opa[g], opb[g]);
                pend_id   = g;
                m_ptr     = (g + 1) % N;
                if (reroll) begin
                    opa[g] = rand_op();
                    opb[g] = rand_op();
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int nres;
        logic [N-1:0] rv;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        reroll    = 1'b0;
        m_known   = 1'b0;
        m_busy    = 1'b0;
        m_valid   = 1'b0;
        m_prod    = '0;
        m_id      = 0;
        m_ptr     = 0;
        pend_prod = '0;
        pend_id   = 0;
        for (int k = 0; k < N; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        @(negedge clk);

        // Reset state
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_prod", 64'(res_prod), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);

        // Single request from requester 2: 3 * -5
        opa[2] = 25'd3;
        opb[2] = 25'h1FFFFFB;
        step(4'b0100, 1'b0, 1'b0);
        chk("single_ready", 64'(last_ready), 64'b0100);
        step('0, 1'b0, 1'b0);
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_prod", 64'(res_prod), 64'h3_FFFF_FFFF_FFF1);
        chk("single_id", 64'(res_id), 64'd2);
        step('0, 1'b1, 1'b0);

        // Most-negative squared
        opa[0] = 25'h1000000;
        opb[0] = 25'h1000000;
        step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("corner_minsq", 64'(res_prod), 64'h1_0000_0000_0000);
        step('0, 1'b1, 1'b0);

        // Max positive times most negative
        opa[1] = 25'h0FFFFFF;
        opb[1] = 25'h1000000;
        step(4'b0010, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("corner_maxmin", 64'(res_prod), 64'h3_0000_0100_0000);
        step('0, 1'b1, 1'b0);

        // Fairness: all valid, downstream always ready
        step('0, 1'b0, 1'b1);
        nres = 0;
        for (int i = 0; i < 16; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("fair_cadence", 64'(res_valid), 64'(i % 2 == 1));
            if (res_valid) begin
                chk("fair_id", 64'(res_id), 64'(nres % 4));
                nres++;
            end
        end
        chk("fair_count", 64'(nres), 64'd8);

        // Backpressure with requester 1 pending
        step('0, 1'b0, 1'b1);
        opa[0] = 25'd7;
        opb[0] = 25'h1FFFFF7;
        step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            chk("bp_no_ready", 64'(last_ready), 64'd0);
            chk("bp_prod_hold", 64'(res_prod), 64'h3_FFFF_FFFF_FFC1);
            chk("bp_id_hold", 64'(res_id), 64'd0);
        end
        step(4'b0010, 1'b1, 1'b0);
        chk("bp_grant1", 64'(last_ready), 64'b0010);

        // Pointer wrap: grant 3, then 0 and 3 valid -> 0
        step('0, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        chk("grant3", 64'(last_ready), 64'b1000);
        step('0, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        chk("wrap_grant0", 64'(last_ready), 64'b0001);

        // Reset while in CALC; pointer must restart at 0
        step('0, 1'b0, 1'b1);
        chk("midrst_valid", 64'(res_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        step(4'b1001, 1'b0, 1'b0);
        chk("midrst_grant0", 64'(last_ready), 64'b0001);
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);

        // Randomized traffic against the model
        reroll = 1'b1;
        for (int k = 0; k < N; k++) begin
            opa[k] = rand_op();
            opb[k] = rand_op();
        end
        for (int i = 0; i < 400; i++) begin
            rv = N'($urandom_range(0, 15));
            step(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
